// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the writeback port arbiter.
// SRC_A..SRC_E are also the select encoding of the 5x1 writeback mux.
package wb_arb_pkg;

   localparam int N_SRC = 5;

   localparam logic [2:0] SRC_A = 3'd0;  // ALU
   localparam logic [2:0] SRC_B = 3'd1;  // load
   localparam logic [2:0] SRC_C = 3'd2;  // PC+4
   localparam logic [2:0] SRC_D = 3'd3;  // imm / LUI
   localparam logic [2:0] SRC_E = 3'd4;  // CSR

   // Round-robin pointer after granting g: wraps 4 -> 0, never reaches 5..7.
   function automatic logic [2:0] next_ptr(input logic [2:0] g);
      return (g == SRC_E) ? SRC_A : g + 3'd1;
   endfunction

   // (base + k) mod 5 for base, k in 0..4.
   function automatic logic [2:0] rr_index(input logic [2:0] base, input logic [2:0] k);
      logic [3:0] s;
      s = {1'b0, base} + {1'b0, k};
      return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
   endfunction

endpackage

// File: rtl/wb_age_counter.sv
// Per-source wait counter. Counts cycles a source has been valid without a
// grant, saturating at MAX_WAIT; starve is the registered "cnt == MAX_WAIT".
module wb_age_counter #(
   parameter int CNT_W    = 3,
   parameter int MAX_WAIT = 7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic             granted,
   output logic [CNT_W-1:0] cnt,
   output logic             starve
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] cnt_next;

   // Clear on idle or grant, otherwise count up and hold at the ceiling.
   always_comb begin
      cnt_next = cnt;
      if (!valid || granted) begin
         cnt_next = '0;
      end else if (cnt != MAX_C) begin
         cnt_next = cnt + CNT_W'(1);
      end
   end

   // Counter and starvation flag registers; flag mirrors the next count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         starve <= 1'b0;
      end else begin
         cnt    <= cnt_next;
         starve <= (cnt_next == MAX_C);
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port among five writeback
// sources and drives the writeback mux select, rd and write enable.
//
// Handshake: source i presents req_valid[i] with a stable req_rd slice; it
// retires in the cycle where req_valid[i] & req_ready[i] is seen at posedge
// clk. req_ready is combinational and at most one-hot; a source may drop
// valid before ready, which abandons the request and clears its wait count.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int RD_W     = 5,
   parameter int MAX_WAIT = 7,
   parameter int CNT_W    = 3,
   parameter int RR_EN    = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_SRC-1:0]      req_valid,
   input  logic [N_SRC*RD_W-1:0] req_rd,
   input  logic                  wb_hold,
   output logic [N_SRC-1:0]      req_ready,
   output logic [2:0]            wb_sel,
   output logic [RD_W-1:0]       wb_rd,
   output logic                  wb_we,
   output logic [N_SRC-1:0]      starve_flag
);

   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WAIT);

   logic [2:0]       ptr;
   logic [CNT_W-1:0] wait_cnt [N_SRC];

   logic       grant_any;
   logic [2:0] grant_idx;
   logic       starve_hit;
   logic [2:0] starve_idx;
   logic       rr_hit;
   logic [2:0] rr_idx;
   logic       fp_hit;
   logic [2:0] fp_idx;
   logic [2:0] cand;

   // One aging counter per source; a source counts as granted when ready.
   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_age
      wb_age_counter #(
         .CNT_W    (CNT_W),
         .MAX_WAIT (MAX_WAIT)
      ) u_age (
         .clk     (clk),
         .rst_n   (rst_n),
         .valid   (req_valid[gi]),
         .granted (req_ready[gi]),
         .cnt     (wait_cnt[gi]),
         .starve  (starve_flag[gi])
      );
   end

   // Candidate pick: starved sources first, then round-robin or fixed priority.
   always_comb begin
      starve_hit = 1'b0;
      starve_idx = SRC_A;
      rr_hit     = 1'b0;
      rr_idx     = SRC_A;
      fp_hit     = 1'b0;
      fp_idx     = SRC_A;
      cand       = SRC_A;

      for (int i = 0; i < N_SRC; i++) begin
         if (!starve_hit && req_valid[i] && (wait_cnt[i] == MAX_C)) begin
            starve_hit = 1'b1;
            starve_idx = 3'(i);
         end
      end

      for (int k = 0; k < N_SRC; k++) begin
         if (!rr_hit && req_valid[rr_index(ptr, 3'(k))]) begin
            rr_hit = 1'b1;
            rr_idx = rr_index(ptr, 3'(k));
         end
      end

      for (int i = 0; i < N_SRC; i++) begin
         if (!fp_hit && req_valid[i]) begin
            fp_hit = 1'b1;
            fp_idx = 3'(i);
         end
      end

      if (starve_hit) begin
         cand = starve_idx;
      end else if (RR_EN != 0) begin
         cand = rr_idx;
      end else begin
         cand = fp_idx;
      end
   end

   // A grant needs the port free, someone asking, and reset released.
   assign grant_any = rst_n && !wb_hold && (req_valid != '0);
   assign grant_idx = cand;

   // Output muxing; everything stays silent without a grant.
   always_comb begin
      req_ready = '0;
      wb_sel    = SRC_A;
      wb_rd     = '0;
      wb_we     = 1'b0;
      if (grant_any) begin
         req_ready = N_SRC'(1) << grant_idx;
         wb_sel    = grant_idx;
         wb_rd     = req_rd[RD_W*grant_idx +: RD_W];
         wb_we     = (req_rd[RD_W*grant_idx +: RD_W] != '0);
      end
   end

   // Round-robin pointer moves past whoever was granted, starved or not.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= SRC_A;
      end else if ((RR_EN != 0) && grant_any) begin
         ptr <= next_ptr(grant_idx);
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: a round-robin instance (MAX_WAIT=7) and a
// fixed-priority instance (MAX_WAIT=3) share the same stimulus and are
// compared every cycle against a reference model of the arbitration rules.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  req_valid;
   logic [24:0] req_rd;
   logic        wb_hold;

   logic [4:0] rdy_r, rdy_f;
   logic [2:0] sel_r, sel_f;
   logic [4:0] rd_r, rd_f;
   logic       we_r, we_f;
   logic [4:0] stv_r, stv_f;

   int checks = 0;
   int errors = 0;

   // Expected outputs per cycle: {rr instance, fp instance}, each 19 bits
   // {ready[4:0], sel[2:0], rd[4:0], we, starve[4:0]}.
   logic [37:0] exp_q[$];

   // Reference model state: per instance wait ages and round-robin pointer.
   int age [2][5];
   int ptr_m [2];
   int maxw [2] = '{7, 3};

   always #5 clk = ~clk;

   wb_port_arbiter #(.RD_W(5), .MAX_WAIT(7), .CNT_W(3), .RR_EN(1)) dut_rr (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rd(req_rd), .wb_hold(wb_hold),
      .req_ready(rdy_r), .wb_sel(sel_r), .wb_rd(rd_r), .wb_we(we_r), .starve_flag(stv_r)
   );

   wb_port_arbiter #(.RD_W(5), .MAX_WAIT(3), .CNT_W(3), .RR_EN(0)) dut_fp (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_rd(req_rd), .wb_hold(wb_hold),
      .req_ready(rdy_f), .wb_sel(sel_f), .wb_rd(rd_f), .wb_we(we_f), .starve_flag(stv_f)
   );

   // Which source the rules grant this cycle, or -1 for none.
   function automatic int pick(int d, logic r, logic [4:0] v, logic h);
      int idx;
      if (!r || h || v == 5'd0) return -1;
      for (int i = 0; i < 5; i++)
         if (v[i] && age[d][i] == maxw[d]) return i;
      if (d == 0) begin
         for (int k = 0; k < 5; k++) begin
            idx = (ptr_m[d] + k) % 5;
            if (v[idx]) return idx;
         end
      end
      for (int i = 0; i < 5; i++)
         if (v[i]) return i;
      return -1;
   endfunction

   // Driver: apply one cycle of inputs, push the expected response, advance the model.
   task automatic drive(input logic r, input logic [4:0] v, input logic h, input logic [24:0] rdv);
      logic [18:0] e [2];
      logic [4:0]  stv;
      logic [4:0]  grd;
      int          g;
      @(negedge clk);
      rst_n     = r;
      req_valid = v;
      wb_hold   = h;
      req_rd    = rdv;
      for (int d = 0; d < 2; d++) begin
         if (!r) begin
            for (int i = 0; i < 5; i++) age[d][i] = 0;
            ptr_m[d] = 0;
         end
         g = pick(d, r, v, h);
         for (int i = 0; i < 5; i++) stv[i] = (age[d][i] == maxw[d]);
         grd = (g >= 0) ? rdv[5*g +: 5] : 5'd0;
         e[d] = {(g >= 0) ? (5'd1 << g) : 5'd0, (g >= 0) ? 3'(g) : 3'd0,
                 grd, (g >= 0) && (grd != 5'd0), stv};
         if (r) begin
            for (int i = 0; i < 5; i++) begin
               if (!v[i] || g == i) age[d][i] = 0;
               else if (age[d][i] < maxw[d]) age[d][i] = age[d][i] + 1;
            end
            if (d == 0 && g >= 0) ptr_m[d] = (g + 1) % 5;
         end
      end
      exp_q.push_back({e[0], e[1]});
   endtask

   task automatic chk(input string name, input int d, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h at %0t", name, d, got, exp, $time);
      end
   endtask

   // Monitor: sample settled outputs mid-cycle and compare against the queue.
   initial begin
      logic [37:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ready",  0, 8'(rdy_r), 8'(e[37:33]));
            chk("sel",    0, 8'(sel_r), 8'(e[32:30]));
            chk("rd",     0, 8'(rd_r),  8'(e[29:25]));
            chk("we",     0, 8'(we_r),  8'(e[24]));
            chk("starve", 0, 8'(stv_r), 8'(e[23:19]));
            chk("ready",  1, 8'(rdy_f), 8'(e[18:14]));
            chk("sel",    1, 8'(sel_f), 8'(e[13:11]));
            chk("rd",     1, 8'(rd_f),  8'(e[10:6]));
            chk("we",     1, 8'(we_f),  8'(e[5]));
            chk("starve", 1, 8'(stv_f), 8'(e[4:0]));
         end
      end
   end

   // Stimulus: directed scenarios followed by a randomized phase.
   initial begin
      logic [24:0] rd_seq;
      logic [24:0] cur_rd;
      logic [4:0]  v;
      rst_n     = 1'b0;
      req_valid = '0;
      wb_hold   = 1'b0;
      req_rd    = '0;
      rd_seq    = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1};

      // Reset with everyone asking, then round-robin over all sources.
      repeat (2) drive(1'b0, 5'b11111, 1'b0, rd_seq);
      repeat (6) drive(1'b1, 5'b11111, 1'b0, rd_seq);

      // Lone write to x0 from src2, then everyone: rr resumes at src3.
      drive(1'b1, 5'b00000, 1'b0, rd_seq);
      drive(1'b1, 5'b00100, 1'b0, {5'd5, 5'd4, 5'd0, 5'd2, 5'd1});
      drive(1'b1, 5'b11111, 1'b0, rd_seq);

      // Two persistent requesters: exercises starvation on the fixed-priority instance.
      drive(1'b1, 5'b00000, 1'b0, rd_seq);
      repeat (9) drive(1'b1, 5'b10001, 1'b0, {5'd9, 5'd4, 5'd3, 5'd2, 5'd7});

      // Hold for three cycles with src1 waiting, then release.
      drive(1'b1, 5'b00000, 1'b0, rd_seq);
      repeat (3) drive(1'b1, 5'b00010, 1'b1, rd_seq);
      drive(1'b1, 5'b00010, 1'b0, rd_seq);

      // Wrap from src4 to src0, then reset pulse in the middle of traffic.
      drive(1'b1, 5'b00000, 1'b0, rd_seq);
      drive(1'b1, 5'b10000, 1'b0, rd_seq);
      repeat (3) drive(1'b1, 5'b11111, 1'b0, rd_seq);
      repeat (2) drive(1'b0, 5'b11111, 1'b0, rd_seq);
      repeat (3) drive(1'b1, 5'b11111, 1'b0, rd_seq);

      // Random traffic; an rd only changes while its source is idle.
      cur_rd = rd_seq;
      for (int n = 0; n < 500; n++) begin
         for (int i = 0; i < 5; i++) begin
            v[i] = ($urandom_range(0, 3) != 0);
            if (!v[i]) cur_rd[5*i +: 5] = 5'($urandom_range(0, 31));
         end
         drive(($urandom_range(0, 99) != 0), v, ($urandom_range(0, 4) == 0), cur_rd);
      end

      @(negedge clk);
      #4;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
